// File: rtl/rf_writeback_queue_pkg.sv
// -----------------------------------------------------------------------------
// rf_writeback_queue_pkg
// Shared constants for the register-file writeback path.
//   WORD_WIDTH  : datapath width of a register value
//   REG_NUM_LOG : register address width
//   REG_ZERO    : index of the hard-wired zero register (writes are dropped)
// -----------------------------------------------------------------------------
package rf_writeback_queue_pkg;

    localparam int WORD_WIDTH  = 32;
    localparam int REG_NUM_LOG = 5;
    localparam int REG_ZERO    = 0;

    // True when a register address names the zero register.
    function automatic logic is_reg_zero(input logic [REG_NUM_LOG-1:0] addr);
        return addr == REG_NUM_LOG'(REG_ZERO);
    endfunction

endpackage

// File: rtl/rf_wbq_fwd_match.sv
// -----------------------------------------------------------------------------
// rf_wbq_fwd_match
// Combinational forwarding lookup over the writeback FIFO plus the register
// file output register. The newest matching write wins; the output register
// is the oldest candidate, followed by the queue from head towards tail.
//
// Ports:
//   i_entry_addr / i_entry_value : FIFO storage, indexed by slot
//   i_head, i_count              : occupied window of the FIFO
//   i_out_en/i_out_addr/i_out_value : write output register
//   i_lookup_addr                : operand register being read
//   o_hit, o_value               : match flag and forwarded value (0 on miss)
// -----------------------------------------------------------------------------
module rf_wbq_fwd_match #(
    parameter int WORD_WIDTH  = 32,
    parameter int REG_NUM_LOG = 5,
    parameter int DEPTH       = 4,
    parameter int PTR_W       = 2
) (
    input  logic [DEPTH-1:0][REG_NUM_LOG-1:0] i_entry_addr,
    input  logic [DEPTH-1:0][WORD_WIDTH-1:0]  i_entry_value,
    input  logic [PTR_W-1:0]                  i_head,
    input  logic [PTR_W:0]                    i_count,
    input  logic                              i_out_en,
    input  logic [REG_NUM_LOG-1:0]            i_out_addr,
    input  logic [WORD_WIDTH-1:0]             i_out_value,
    input  logic [REG_NUM_LOG-1:0]            i_lookup_addr,
    output logic                              o_hit,
    output logic [WORD_WIDTH-1:0]             o_value
);
    import rf_writeback_queue_pkg::*;

    logic [PTR_W-1:0] w_idx;

    always_comb begin
        o_hit   = 1'b0;
        o_value = '0;
        w_idx   = '0;
        if (i_out_en && (i_out_addr == i_lookup_addr)) begin
            o_hit   = 1'b1;
            o_value = i_out_value;
        end
        // Walk oldest to newest so a later match overrides an earlier one.
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = i_head + PTR_W'(k);
            if ((PTR_W+1)'(k) < i_count && i_entry_addr[w_idx] == i_lookup_addr) begin
                o_hit   = 1'b1;
                o_value = i_entry_value[w_idx];
            end
        end
        // The zero register always reads as a constant; never forward it.
        if (is_reg_zero(i_lookup_addr)) begin
            o_hit   = 1'b0;
            o_value = '0;
        end
    end

endmodule

// File: rtl/rf_writeback_queue.sv
// -----------------------------------------------------------------------------
// rf_writeback_queue
// Writer-side front end for the register file write port. ALU and load
// results enter a small in-order FIFO (ALU older when both arrive together),
// one entry drains per cycle into registered writeEnable/writeAddr/writeValue,
// and two forwarding ports expose results still queued or in the output reg.
//
// Ports:
//   clk, rst (async, active low)
//   alu_valid/alu_ready/alu_addr/alu_value : ALU producer
//   mem_valid/mem_ready/mem_addr/mem_value : load producer
//   writeEnable/writeAddr/writeValue       : register file write port
//   fwd_addr_*/fwd_hit_*/fwd_value_*       : left/right operand forwarding
//   count                                  : occupied FIFO entries
// -----------------------------------------------------------------------------
module rf_writeback_queue #(
    parameter int WORD_WIDTH  = rf_writeback_queue_pkg::WORD_WIDTH,
    parameter int REG_NUM_LOG = rf_writeback_queue_pkg::REG_NUM_LOG,
    parameter int DEPTH       = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   alu_valid,
    output logic                   alu_ready,
    input  logic [REG_NUM_LOG-1:0] alu_addr,
    input  logic [WORD_WIDTH-1:0]  alu_value,
    input  logic                   mem_valid,
    output logic                   mem_ready,
    input  logic [REG_NUM_LOG-1:0] mem_addr,
    input  logic [WORD_WIDTH-1:0]  mem_value,
    output logic                   writeEnable,
    output logic [REG_NUM_LOG-1:0] writeAddr,
    output logic [WORD_WIDTH-1:0]  writeValue,
    input  logic [REG_NUM_LOG-1:0] fwd_addr_left,
    output logic                   fwd_hit_left,
    output logic [WORD_WIDTH-1:0]  fwd_value_left,
    input  logic [REG_NUM_LOG-1:0] fwd_addr_right,
    output logic                   fwd_hit_right,
    output logic [WORD_WIDTH-1:0]  fwd_value_right,
    output logic [$clog2(DEPTH):0] count
);
    import rf_writeback_queue_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Queue state
    logic [PTR_W-1:0]                  r_head;
    logic [PTR_W-1:0]                  r_tail;
    logic [CNT_W-1:0]                  r_count;
    logic [DEPTH-1:0][REG_NUM_LOG-1:0] r_entry_addr;
    logic [DEPTH-1:0][WORD_WIDTH-1:0]  r_entry_value;

    // Register file output register
    logic                   r_we;
    logic [REG_NUM_LOG-1:0] r_waddr;
    logic [WORD_WIDTH-1:0]  r_wvalue;

    logic [CNT_W-1:0] w_free;
    logic             w_alu_ready;
    logic             w_mem_ready;
    logic             w_alu_push;
    logic             w_mem_push;
    logic             w_pop;
    logic [PTR_W-1:0] w_alu_slot;
    logic [PTR_W-1:0] w_mem_slot;
    logic [PTR_W-1:0] w_tail_next;
    logic [PTR_W-1:0] w_head_next;
    logic [CNT_W-1:0] w_count_next;
    logic [DEPTH-1:0] w_wr_alu;
    logic [DEPTH-1:0] w_wr_mem;

    logic                  w_hit_left;
    logic                  w_hit_right;
    logic [WORD_WIDTH-1:0] w_value_left;
    logic [WORD_WIDTH-1:0] w_value_right;

    // Readiness looks only at the registered count, so neither ready depends
    // on a valid. The load port asks for two free slots because it may arrive
    // together with an ALU result that takes the first one.
    assign w_free      = CNT_W'(DEPTH) - r_count;
    assign w_alu_ready = rst && (w_free >= CNT_W'(1));
    assign w_mem_ready = rst && (w_free >= CNT_W'(2));

    // Writes to the zero register complete the handshake but are not stored.
    assign w_alu_push = alu_valid && w_alu_ready && !is_reg_zero(alu_addr);
    assign w_mem_push = mem_valid && w_mem_ready && !is_reg_zero(mem_addr);
    assign w_pop      = (r_count != '0);

    // ALU takes the tail slot; the load lands right behind it when both push.
    assign w_alu_slot   = r_tail;
    assign w_mem_slot   = r_tail + PTR_W'(w_alu_push);
    assign w_tail_next  = r_tail + PTR_W'(w_alu_push) + PTR_W'(w_mem_push);
    assign w_head_next  = r_head + PTR_W'(w_pop);
    assign w_count_next = r_count + CNT_W'(w_alu_push) + CNT_W'(w_mem_push)
                        - CNT_W'(w_pop);

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot_we
            assign w_wr_alu[gi] = w_alu_push && (w_alu_slot == PTR_W'(gi));
            assign w_wr_mem[gi] = w_mem_push && (w_mem_slot == PTR_W'(gi));
        end
    endgenerate

    // Entry payload needs no reset; occupancy is tracked by head/count.
    always_ff @(posedge clk) begin
        for (int k = 0; k < DEPTH; k++) begin
            if (w_wr_mem[k]) begin
                r_entry_addr[k]  <= mem_addr;
                r_entry_value[k] <= mem_value;
            end else if (w_wr_alu[k]) begin
                r_entry_addr[k]  <= alu_addr;
                r_entry_value[k] <= alu_value;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= w_head_next;
            r_tail  <= w_tail_next;
            r_count <= w_count_next;
        end
    end

    // Output register: strobe follows the pop; address/data hold when idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_we     <= 1'b0;
            r_waddr  <= '0;
            r_wvalue <= '0;
        end else begin
            r_we <= w_pop;
            if (w_pop) begin
                r_waddr  <= r_entry_addr[r_head];
                r_wvalue <= r_entry_value[r_head];
            end
        end
    end

    rf_wbq_fwd_match #(
        .WORD_WIDTH  (WORD_WIDTH),
        .REG_NUM_LOG (REG_NUM_LOG),
        .DEPTH       (DEPTH),
        .PTR_W       (PTR_W)
    ) u_fwd_left (
        .i_entry_addr  (r_entry_addr),
        .i_entry_value (r_entry_value),
        .i_head        (r_head),
        .i_count       (r_count),
        .i_out_en      (r_we),
        .i_out_addr    (r_waddr),
        .i_out_value   (r_wvalue),
        .i_lookup_addr (fwd_addr_left),
        .o_hit         (w_hit_left),
        .o_value       (w_value_left)
    );

    rf_wbq_fwd_match #(
        .WORD_WIDTH  (WORD_WIDTH),
        .REG_NUM_LOG (REG_NUM_LOG),
        .DEPTH       (DEPTH),
        .PTR_W       (PTR_W)
    ) u_fwd_right (
        .i_entry_addr  (r_entry_addr),
        .i_entry_value (r_entry_value),
        .i_head        (r_head),
        .i_count       (r_count),
        .i_out_en      (r_we),
        .i_out_addr    (r_waddr),
        .i_out_value   (r_wvalue),
        .i_lookup_addr (fwd_addr_right),
        .o_hit         (w_hit_right),
        .o_value       (w_value_right)
    );

    assign alu_ready       = w_alu_ready;
    assign mem_ready       = w_mem_ready;
    assign writeEnable     = r_we;
    assign writeAddr       = r_waddr;
    assign writeValue      = r_wvalue;
    assign count           = r_count;
    assign fwd_hit_left    = rst && w_hit_left;
    assign fwd_value_left  = rst ? w_value_left : '0;
    assign fwd_hit_right   = rst && w_hit_right;
    assign fwd_value_right = rst ? w_value_right : '0;

endmodule

// File: tb/tb_rf_writeback_queue.sv
// -----------------------------------------------------------------------------
// tb_rf_writeback_queue
// Directed bench for rf_writeback_queue. Inputs change on the negedge and
// outputs are sampled on the negedge, half a cycle away from the active edge.
// -----------------------------------------------------------------------------
module tb_rf_writeback_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_addr;
    logic [31:0] alu_value;
    logic        mem_valid;
    logic        mem_ready;
    logic [4:0]  mem_addr;
    logic [31:0] mem_value;
    logic        writeEnable;
    logic [4:0]  writeAddr;
    logic [31:0] writeValue;
    logic [4:0]  fwd_addr_left;
    logic        fwd_hit_left;
    logic [31:0] fwd_value_left;
    logic [4:0]  fwd_addr_right;
    logic        fwd_hit_right;
    logic [31:0] fwd_value_right;
    logic [2:0]  count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rf_writeback_queue #(.WORD_WIDTH(32), .REG_NUM_LOG(5), .DEPTH(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .alu_valid       (alu_valid),
        .alu_ready       (alu_ready),
        .alu_addr        (alu_addr),
        .alu_value       (alu_value),
        .mem_valid       (mem_valid),
        .mem_ready       (mem_ready),
        .mem_addr        (mem_addr),
        .mem_value       (mem_value),
        .writeEnable     (writeEnable),
        .writeAddr       (writeAddr),
        .writeValue      (writeValue),
        .fwd_addr_left   (fwd_addr_left),
        .fwd_hit_left    (fwd_hit_left),
        .fwd_value_left  (fwd_value_left),
        .fwd_addr_right  (fwd_addr_right),
        .fwd_hit_right   (fwd_hit_right),
        .fwd_value_right (fwd_value_right),
        .count           (count)
    );

    task automatic clear_inputs();
        alu_valid = 1'b0; alu_addr = '0; alu_value = '0;
        mem_valid = 1'b0; mem_addr = '0; mem_value = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        fwd_addr_left = 5'd0; fwd_addr_right = 5'd0;
        #1 rst = 1'b0;
        #1;
        total++; if (count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
        total++; if (writeEnable !== 1'b0) begin bad++; $display("FAIL reset_we got=%b exp=0", writeEnable); end
        total++; if (writeAddr !== 5'd0) begin bad++; $display("FAIL reset_waddr got=%0d exp=0", writeAddr); end
        total++; if (writeValue !== 32'd0) begin bad++; $display("FAIL reset_wvalue got=%h exp=0", writeValue); end
        total++; if (alu_ready !== 1'b0 || mem_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b%b exp=00", alu_ready, mem_ready); end
        total++; if (fwd_hit_left !== 1'b0) begin bad++; $display("FAIL reset_hit got=%b exp=0", fwd_hit_left); end
        @(negedge clk); rst = 1'b1;
        #1;
        total++; if (alu_ready !== 1'b1 || mem_ready !== 1'b1) begin bad++; $display("FAIL post_reset_ready got=%b%b exp=11", alu_ready, mem_ready); end
        $display("reset: checked");
    endtask

    task automatic test_single();
        @(negedge clk);
        alu_valid = 1'b1; alu_addr = 5'd3; alu_value = 32'h11; fwd_addr_left = 5'd3;
        @(negedge clk);
        clear_inputs();
        total++; if (count !== 3'd1) begin bad++; $display("FAIL single_count1 got=%0d exp=1", count); end
        total++; if (writeEnable !== 1'b0) begin bad++; $display("FAIL single_we_early got=%b exp=0", writeEnable); end
        total++; if (fwd_hit_left !== 1'b1 || fwd_value_left !== 32'h11) begin bad++; $display("FAIL single_fwd_q got=%b/%h exp=1/11", fwd_hit_left, fwd_value_left); end
        @(negedge clk);
        total++; if (writeEnable !== 1'b1 || writeAddr !== 5'd3 || writeValue !== 32'h11) begin bad++; $display("FAIL single_write got=%b/%0d/%h exp=1/3/11", writeEnable, writeAddr, writeValue); end
        total++; if (count !== 3'd0) begin bad++; $display("FAIL single_count0 got=%0d exp=0", count); end
        total++; if (fwd_hit_left !== 1'b1 || fwd_value_left !== 32'h11) begin bad++; $display("FAIL single_fwd_out got=%b/%h exp=1/11", fwd_hit_left, fwd_value_left); end
        @(negedge clk);
        total++; if (writeEnable !== 1'b0 || writeAddr !== 5'd3) begin bad++; $display("FAIL single_after got=%b/%0d exp=0/3", writeEnable, writeAddr); end
        total++; if (fwd_hit_left !== 1'b0 || fwd_value_left !== 32'h0) begin bad++; $display("FAIL single_fwd_gone got=%b/%h exp=0/0", fwd_hit_left, fwd_value_left); end
        $display("single: r3=0x11 written once");
    endtask

    task automatic test_same_reg();
        @(negedge clk);
        alu_valid = 1'b1; alu_addr = 5'd5; alu_value = 32'hA;
        mem_valid = 1'b1; mem_addr = 5'd5; mem_value = 32'hB;
        fwd_addr_left = 5'd5;
        total++; if (mem_ready !== 1'b1 || alu_ready !== 1'b1) begin bad++; $display("FAIL same_ready got=%b%b exp=11", alu_ready, mem_ready); end
        @(negedge clk);
        clear_inputs();
        total++; if (count !== 3'd2) begin bad++; $display("FAIL same_count got=%0d exp=2", count); end
        total++; if (fwd_hit_left !== 1'b1 || fwd_value_left !== 32'hB) begin bad++; $display("FAIL same_fwd0 got=%b/%h exp=1/b", fwd_hit_left, fwd_value_left); end
        @(negedge clk);
        total++; if (writeEnable !== 1'b1 || writeAddr !== 5'd5 || writeValue !== 32'hA) begin bad++; $display("FAIL same_w1 got=%b/%0d/%h exp=1/5/a", writeEnable, writeAddr, writeValue); end
        total++; if (fwd_hit_left !== 1'b1 || fwd_value_left !== 32'hB) begin bad++; $display("FAIL same_fwd1 got=%b/%h exp=1/b", fwd_hit_left, fwd_value_left); end
        @(negedge clk);
        total++; if (writeEnable !== 1'b1 || writeAddr !== 5'd5 || writeValue !== 32'hB) begin bad++; $display("FAIL same_w2 got=%b/%0d/%h exp=1/5/b", writeEnable, writeAddr, writeValue); end
        total++; if (fwd_hit_left !== 1'b1 || fwd_value_left !== 32'hB) begin bad++; $display("FAIL same_fwd2 got=%b/%h exp=1/b", fwd_hit_left, fwd_value_left); end
        @(negedge clk);
        total++; if (writeEnable !== 1'b0 || fwd_hit_left !== 1'b0) begin bad++; $display("FAIL same_idle got=%b/%b exp=0/0", writeEnable, fwd_hit_left); end
        $display("same_reg: r5 A then B");
    endtask

    // Both producers valid every cycle. Count goes 0 -> 2 -> 3 and saturates
    // at 3 (one pop per cycle), so mem_ready drops from the third cycle on.
    // Accepted order: a0 m0 a1 m1 a2..a9 (12 entries, pointers wrap 3 times).
    task automatic test_back_to_back();
        logic [4:0]  obs_addr[$];
        logic [31:0] obs_val[$];
        logic [4:0]  exp_addr[$];
        logic [31:0] exp_val[$];
        exp_addr = '{5'd1, 5'd16, 5'd2, 5'd17, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10};
        exp_val  = '{32'h100, 32'h200, 32'h101, 32'h201, 32'h102, 32'h103,
                     32'h104, 32'h105, 32'h106, 32'h107, 32'h108, 32'h109};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (writeEnable === 1'b1) begin obs_addr.push_back(writeAddr); obs_val.push_back(writeValue); end
            if (i > 0) begin
                total++; if (count !== ((i == 1) ? 3'd2 : 3'd3)) begin bad++; $display("FAIL b2b_count[%0d] got=%0d exp=%0d", i, count, (i == 1) ? 2 : 3); end
            end
            alu_valid = 1'b1; alu_addr = 5'(i + 1);  alu_value = 32'h100 + 32'(i);
            mem_valid = 1'b1; mem_addr = 5'(i + 16); mem_value = 32'h200 + 32'(i);
            total++; if (alu_ready !== 1'b1) begin bad++; $display("FAIL b2b_alu_ready[%0d] got=%b exp=1", i, alu_ready); end
            total++; if (mem_ready !== (i < 2)) begin bad++; $display("FAIL b2b_mem_ready[%0d] got=%b exp=%b", i, mem_ready, i < 2); end
        end
        @(negedge clk);
        clear_inputs();
        total++; if (count !== 3'd3) begin bad++; $display("FAIL b2b_count_last got=%0d exp=3", count); end
        if (writeEnable === 1'b1) begin obs_addr.push_back(writeAddr); obs_val.push_back(writeValue); end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (writeEnable === 1'b1) begin obs_addr.push_back(writeAddr); obs_val.push_back(writeValue); end
        end
        total++; if (obs_addr.size() != 12) begin bad++; $display("FAIL b2b_writes got=%0d exp=12", obs_addr.size()); end
        for (int i = 0; i < 12 && i < obs_addr.size(); i++) begin
            total++;
            if (obs_addr[i] !== exp_addr[i] || obs_val[i] !== exp_val[i]) begin
                bad++; $display("FAIL b2b_order[%0d] got=%0d/%h exp=%0d/%h", i, obs_addr[i], obs_val[i], exp_addr[i], exp_val[i]);
            end
        end
        total++; if (count !== 3'd0) begin bad++; $display("FAIL b2b_drained got=%0d exp=0", count); end
        $display("back_to_back: %0d writes observed", obs_addr.size());
    endtask

    task automatic test_r0();
        @(negedge clk);
        alu_valid = 1'b1; alu_addr = 5'd0; alu_value = 32'hFFFF; fwd_addr_left = 5'd0;
        total++; if (alu_ready !== 1'b1) begin bad++; $display("FAIL r0_ready got=%b exp=1", alu_ready); end
        @(negedge clk);
        clear_inputs();
        total++; if (count !== 3'd0 || writeEnable !== 1'b0) begin bad++; $display("FAIL r0_not_stored got=%0d/%b exp=0/0", count, writeEnable); end
        total++; if (fwd_hit_left !== 1'b0) begin bad++; $display("FAIL r0_fwd got=%b exp=0", fwd_hit_left); end
        @(negedge clk);
        total++; if (writeEnable !== 1'b0) begin bad++; $display("FAIL r0_no_write got=%b exp=0", writeEnable); end
        $display("r0: write dropped");
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        alu_valid = 1'b1; alu_addr = 5'd9;  alu_value = 32'h90;
        mem_valid = 1'b1; mem_addr = 5'd10; mem_value = 32'hA0;
        fwd_addr_left = 5'd11;
        @(negedge clk);
        alu_addr = 5'd11; alu_value = 32'hB0;
        mem_addr = 5'd12; mem_value = 32'hC0;
        @(negedge clk);
        clear_inputs();
        total++; if (count !== 3'd3 || writeEnable !== 1'b1) begin bad++; $display("FAIL ar_pre got=%0d/%b exp=3/1", count, writeEnable); end
        total++; if (fwd_hit_left !== 1'b1 || fwd_value_left !== 32'hB0) begin bad++; $display("FAIL ar_pre_fwd got=%b/%h exp=1/b0", fwd_hit_left, fwd_value_left); end
        #2 rst = 1'b0;
        #1;
        total++; if (count !== 3'd0) begin bad++; $display("FAIL ar_count got=%0d exp=0", count); end
        total++; if (writeEnable !== 1'b0 || writeAddr !== 5'd0 || writeValue !== 32'd0) begin bad++; $display("FAIL ar_write got=%b/%0d/%h exp=0/0/0", writeEnable, writeAddr, writeValue); end
        total++; if (alu_ready !== 1'b0 || mem_ready !== 1'b0 || fwd_hit_left !== 1'b0) begin bad++; $display("FAIL ar_ready_hit got=%b%b%b exp=000", alu_ready, mem_ready, fwd_hit_left); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total++; if (count !== 3'd0 || writeEnable !== 1'b0) begin bad++; $display("FAIL ar_after1 got=%0d/%b exp=0/0", count, writeEnable); end
        @(negedge clk);
        total++; if (writeEnable !== 1'b0) begin bad++; $display("FAIL ar_after2 got=%b exp=0", writeEnable); end
        $display("async_reset: cleared mid-operation");
    endtask

    task automatic test_fwd_pipeline();
        @(negedge clk);
        alu_valid = 1'b1; alu_addr = 5'd7; alu_value = 32'h42;
        fwd_addr_right = 5'd7; fwd_addr_left = 5'd6;
        @(negedge clk);
        alu_value = 32'h43;
        total++; if (count !== 3'd1 || fwd_hit_right !== 1'b1 || fwd_value_right !== 32'h42) begin bad++; $display("FAIL fp_q got=%0d/%b/%h exp=1/1/42", count, fwd_hit_right, fwd_value_right); end
        @(negedge clk);
        clear_inputs();
        total++; if (writeEnable !== 1'b1 || writeAddr !== 5'd7 || writeValue !== 32'h42) begin bad++; $display("FAIL fp_out got=%b/%0d/%h exp=1/7/42", writeEnable, writeAddr, writeValue); end
        total++; if (fwd_hit_right !== 1'b1 || fwd_value_right !== 32'h43) begin bad++; $display("FAIL fp_newest got=%b/%h exp=1/43", fwd_hit_right, fwd_value_right); end
        total++; if (fwd_hit_left !== 1'b0 || fwd_value_left !== 32'h0) begin bad++; $display("FAIL fp_left_miss got=%b/%h exp=0/0", fwd_hit_left, fwd_value_left); end
        @(negedge clk);
        total++; if (writeValue !== 32'h43 || count !== 3'd0 || fwd_value_right !== 32'h43) begin bad++; $display("FAIL fp_second got=%h/%0d/%h exp=43/0/43", writeValue, count, fwd_value_right); end
        @(negedge clk);
        total++; if (writeEnable !== 1'b0 || fwd_hit_right !== 1'b0 || fwd_value_right !== 32'h0) begin bad++; $display("FAIL fp_drained got=%b/%b/%h exp=0/0/0", writeEnable, fwd_hit_right, fwd_value_right); end
        $display("fwd_pipeline: r7 newest value forwarded");
    endtask

    initial begin
        test_reset();
        test_single();
        test_same_reg();
        test_back_to_back();
        test_r0();
        test_async_reset();
        test_fwd_pipeline();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
